// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block/word geometry, padding constants, padder FSM
// encoding, and the IV/K tables consumed by the hash core.
package sha256_pkg;
    localparam int WORD_W = 32;
    localparam int BLOCK_W = 512;
    localparam int LEN_W = 64;
    localparam logic [7:0] PAD_MARKER = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SEND = 2'd1,
        ST_TAIL = 2'd2
    } pad_state_e;

    localparam logic [0:7][31:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] SHA256_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
endpackage

// File: rtl/sha256_msg_padder_if.sv
// Word-stream input and padded-block output of the message padder, bundled so
// the padder and its host/core environment share one connection.
interface sha256_msg_padder_if;
    import sha256_pkg::*;

    // Both streams transfer on a cycle where valid & ready are high at the rising
    // edge; a source holds valid and its payload stable until that transfer happens.
    logic [WORD_W-1:0]  in_data;
    logic [2:0]         in_bytes;
    logic               in_last;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] blk_data;
    logic               blk_valid;
    logic               blk_ready;
    logic               blk_last;
    logic [LEN_W-1:0]   blk_index;

    modport master (
        input  in_data, in_bytes, in_last, in_valid, blk_ready,
        output in_ready, blk_data, blk_valid, blk_last, blk_index
    );

    modport slave (
        output in_data, in_bytes, in_last, in_valid, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_last, blk_index
    );
endinterface

// File: rtl/sha256_pad_word.sv
// Masks a message word to its valid leading bytes and, when enabled, drops the
// 0x80 pad marker into the first unused byte lane.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] data_i,
    input  logic [2:0]        bytes_i,
    input  logic              marker_en_i,
    output logic [WORD_W-1:0] word_o
);
    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(bytes_i)) begin
                word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
            end else if (marker_en_i && (b == int'(bytes_i))) begin
                word_o[31-8*b -: 8] = PAD_MARKER;
            end
        end
    end
endmodule

// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: collects big-endian words into a 16-word buffer and
// emits padded 512-bit blocks, adding a length-only tail block when needed.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int BYTE_CNT_W = 61
) (
    input  logic                clk,
    input  logic                rst,
    sha256_msg_padder_if.master bus,
    output pad_state_e          state_o
);
    pad_state_e              state_q;
    logic [0:15][WORD_W-1:0] buf_q;
    logic [3:0]              widx_q;
    logic [BYTE_CNT_W-1:0]   cnt_q;
    logic                    tail_pending_q;
    logic                    tail_marker_q;
    logic                    blk_last_q;
    logic                    blk_valid_q;
    logic                    in_ready_q;
    logic [LEN_W-1:0]        blk_index_q;

    logic [2:0]              eff_bytes_d;
    logic [BYTE_CNT_W-1:0]   cnt_d;
    logic [LEN_W-1:0]        len_d;
    logic [LEN_W-1:0]        len_q;
    logic [4:0]              marker_idx_d;
    logic [WORD_W-1:0]       pad_word_d;
    logic [0:15][WORD_W-1:0] tail_blk_d;
    logic                    accept;
    logic                    blk_hs;

    // A short word without in_last is malformed; count it as a full word.
    assign eff_bytes_d  = (!bus.in_last || (bus.in_bytes > 3'd4)) ? 3'd4 : bus.in_bytes;
    assign cnt_d        = cnt_q + BYTE_CNT_W'(eff_bytes_d);
    assign len_d        = LEN_W'({cnt_d, 3'b000});
    assign len_q        = LEN_W'({cnt_q, 3'b000});
    assign marker_idx_d = {1'b0, widx_q} + ((eff_bytes_d == 3'd4) ? 5'd1 : 5'd0);
    assign accept       = bus.in_valid & in_ready_q;
    assign blk_hs       = blk_valid_q & bus.blk_ready;

    sha256_pad_word u_pad_word (
        .data_i      (bus.in_data),
        .bytes_i     (eff_bytes_d),
        .marker_en_i (bus.in_last),
        .word_o      (pad_word_d)
    );

    always_comb begin
        tail_blk_d     = '0;
        tail_blk_d[0]  = tail_marker_q ? {PAD_MARKER, 24'h0} : '0;
        tail_blk_d[14] = len_q[63:32];
        tail_blk_d[15] = len_q[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_FILL;
            buf_q          <= '0;
            widx_q         <= '0;
            cnt_q          <= '0;
            tail_pending_q <= 1'b0;
            tail_marker_q  <= 1'b0;
            blk_last_q     <= 1'b0;
            blk_valid_q    <= 1'b0;
            in_ready_q     <= 1'b1;
            blk_index_q    <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        buf_q[widx_q] <= pad_word_d;
                        cnt_q         <= cnt_d;
                        if (!bus.in_last) begin
                            widx_q <= widx_q + 4'd1;
                            if (widx_q == 4'd15) begin
                                state_q     <= ST_SEND;
                                in_ready_q  <= 1'b0;
                                blk_valid_q <= 1'b1;
                                blk_last_q  <= 1'b0;
                                blk_index_q <= blk_index_q + LEN_W'(1);
                            end
                        end else begin
                            // A full last word pushes the marker into the next word.
                            if ((eff_bytes_d == 3'd4) && (widx_q != 4'd15)) begin
                                buf_q[widx_q + 4'd1] <= {PAD_MARKER, 24'h0};
                            end
                            if (marker_idx_d <= 5'd13) begin
                                buf_q[14]  <= len_d[63:32];
                                buf_q[15]  <= len_d[31:0];
                                blk_last_q <= 1'b1;
                            end else begin
                                tail_pending_q <= 1'b1;
                                tail_marker_q  <= (marker_idx_d == 5'd16);
                                blk_last_q     <= 1'b0;
                            end
                            state_q     <= ST_SEND;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            blk_index_q <= blk_index_q + LEN_W'(1);
                        end
                    end
                end
                ST_SEND: begin
                    if (blk_hs) begin
                        if (tail_pending_q) begin
                            buf_q          <= tail_blk_d;
                            tail_pending_q <= 1'b0;
                            tail_marker_q  <= 1'b0;
                            blk_last_q     <= 1'b1;
                            blk_index_q    <= blk_index_q + LEN_W'(1);
                            state_q        <= ST_TAIL;
                        end else begin
                            buf_q       <= '0;
                            widx_q      <= '0;
                            blk_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= ST_FILL;
                            if (blk_last_q) begin
                                cnt_q       <= '0;
                                blk_index_q <= '0;
                                blk_last_q  <= 1'b0;
                            end
                        end
                    end
                end
                ST_TAIL: begin
                    if (blk_hs) begin
                        buf_q       <= '0;
                        widx_q      <= '0;
                        cnt_q       <= '0;
                        blk_index_q <= '0;
                        blk_last_q  <= 1'b0;
                        blk_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_FILL;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.blk_data  = buf_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_last  = blk_last_q;
    assign bus.blk_index = blk_index_q;
    assign state_o       = state_q;
endmodule
